// File: rtl/proc_control_unit.sv
// Multi-cycle fetch/decode/execute sequencer for the 16-bit, 8-operation ALU datapath.
// Owns PC and IR. Every output is decoded from state and IR alone, so reset clears strobes at once.
//
// state  | meaning
// INIT   | post-reset, pc cleared
// FETCH  | ir <= rom[pc], pc <= pc + 1
// DECODE | select the execute path from op
// EXEC   | ALU op, RF[d] <= ALU(RF[a], RF[b])
// STORE  | D[ir[7:0]] <= RF[a]
// LOAD_A | issue synchronous RAM read at ir[11:4]
// LOAD_B | RF[d] <= RAM read data
// HALT   | stopped until reset
module proc_control_unit #(
  parameter int PC_W    = 7,
  parameter int DADDR_W = 8,
  parameter int RF_AW   = 4,
  parameter int SEL_W   = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [15:0]        instr_data,
  output logic [PC_W-1:0]    pc_addr,
  output logic [DADDR_W-1:0] d_addr,
  output logic               d_we,
  output logic [RF_AW-1:0]   rf_ra,
  output logic [RF_AW-1:0]   rf_rb,
  output logic [RF_AW-1:0]   rf_wa,
  output logic               rf_we,
  output logic               rf_wsel,
  output logic [SEL_W-1:0]   alu_sel,
  output logic               halted,
  output logic [2:0]         state_o
);

  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_STORE  = 3'd4,
    S_LOAD_A = 3'd5,
    S_LOAD_B = 3'd6,
    S_HALT   = 3'd7
  } state_t;

  localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q;
  logic [15:0]     ir_q;
  logic [3:0]      op;

  assign op = ir_q[15:12];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_INIT;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_INIT:  pc_q <= '0;
        S_FETCH: begin
          ir_q <= instr_data;
          pc_q <= pc_q + PC_ONE;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT:   state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        if (op[3]) begin
          state_d = S_EXEC;
        end else begin
          case (op[2:0])
            3'b001:  state_d = S_LOAD_A;
            3'b010:  state_d = S_STORE;
            3'b011:  state_d = S_HALT;
            default: state_d = S_FETCH;   // NOOP and reserved 01xx
          endcase
        end
      end
      S_EXEC, S_STORE, S_LOAD_B: state_d = S_FETCH;
      S_LOAD_A: state_d = S_LOAD_B;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_INIT;
    endcase
  end

  always_comb begin
    d_addr  = '0;
    d_we    = 1'b0;
    rf_ra   = '0;
    rf_rb   = '0;
    rf_wa   = '0;
    rf_we   = 1'b0;
    rf_wsel = 1'b0;
    alu_sel = '0;
    case (state_q)
      S_EXEC: begin
        rf_ra   = RF_AW'(ir_q[11:8]);
        rf_rb   = RF_AW'(ir_q[7:4]);
        rf_wa   = RF_AW'(ir_q[3:0]);
        alu_sel = SEL_W'(ir_q[14:12]);
        rf_we   = 1'b1;
      end
      S_STORE: begin
        rf_ra  = RF_AW'(ir_q[11:8]);
        d_addr = DADDR_W'(ir_q[7:0]);
        d_we   = 1'b1;
      end
      S_LOAD_A: begin
        d_addr  = DADDR_W'(ir_q[11:4]);
        rf_wsel = 1'b1;
      end
      S_LOAD_B: begin
        d_addr  = DADDR_W'(ir_q[11:4]);
        rf_wsel = 1'b1;
        rf_wa   = RF_AW'(ir_q[3:0]);
        rf_we   = 1'b1;
      end
      default: ;
    endcase
  end

  assign pc_addr = pc_q;
  assign halted  = (state_q == S_HALT);
  assign state_o = state_q;

endmodule
